// File: rtl/clk_div_gen_if.sv
// Control and status bundle of the programmable clock divider.
// master = requester (drives en/div_val), slave = the divider itself.
interface clk_div_gen_if #(
    parameter int WIDTH  = 8,
    parameter int PWIDTH = 16
);
    logic              en;
    logic [WIDTH-1:0]  div_val;
    logic              clk_out;
    logic              tick;
    logic              busy;
    logic [PWIDTH-1:0] period_cnt;

    modport master (
        output en, div_val,
        input  clk_out, tick, busy, period_cnt
    );

    modport slave (
        input  en, div_val,
        output clk_out, tick, busy, period_cnt
    );
endinterface

// File: rtl/clk_div_gen.sv
// Programmable integer divider: registered clk_out, period-start tick, wrapping period counter.
// The ratio is reloaded only at period boundaries; a stop always finishes the current period.
//
//   state | meaning
//   IDLE  | outputs low, counter parked at 0, waiting for en
//   RUN   | generating periods, en sampled every edge
//   STOP  | stop latched, current period runs to completion
module clk_div_gen #(
    parameter int WIDTH  = 8,
    parameter int PWIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    clk_div_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]  ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0]  TWO   = WIDTH'(2);
    localparam logic [PWIDTH-1:0] P_ONE = PWIDTH'(1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  n_act_q, n_act_d;
    logic              clk_out_q, clk_out_d;
    logic              tick_q, tick_d;
    logic [PWIDTH-1:0] period_cnt_q, period_cnt_d;

    logic [WIDTH-1:0]  eff_div;
    logic [WIDTH-1:0]  h_val;
    logic              period_end;
    logic              high_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            n_act_q      <= TWO;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            period_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            n_act_q      <= n_act_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            period_cnt_q <= period_cnt_d;
        end
    end

    // High phase is the larger half for odd ratios; both derived from the latched ratio only.
    always_comb begin
        eff_div    = (bus.div_val < TWO) ? TWO : bus.div_val;
        h_val      = n_act_q - (n_act_q >> 1);
        period_end = (cnt_q == (n_act_q - ONE));
        high_end   = (cnt_q == (h_val - ONE));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.en) state_d = RUN;
            RUN: begin
                if (period_end)   state_d = bus.en ? RUN : IDLE;
                else if (!bus.en) state_d = STOP;
            end
            STOP: if (period_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        n_act_d      = n_act_q;
        clk_out_d    = clk_out_q;
        tick_d       = 1'b0;
        period_cnt_d = period_cnt_q;
        if (state_q == IDLE) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            if (bus.en) begin
                n_act_d   = eff_div;
                clk_out_d = 1'b1;
                tick_d    = 1'b1;
            end
        end else if (period_end) begin
            period_cnt_d = period_cnt_q + P_ONE;
            cnt_d        = '0;
            // A stop seen on the final edge goes straight to IDLE without a STOP cycle.
            if (state_q == RUN && bus.en) begin
                n_act_d   = eff_div;
                clk_out_d = 1'b1;
                tick_d    = 1'b1;
            end else begin
                clk_out_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + ONE;
            if (high_end) clk_out_d = 1'b0;
        end
    end

    always_comb begin
        bus.clk_out    = clk_out_q;
        bus.tick       = tick_q;
        bus.busy       = (state_q != IDLE);
        bus.period_cnt = period_cnt_q;
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: a position-in-period model checked every cycle, plus directed
// literal expectations for the listed scenarios.
module tb_clk_div_gen;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    clk_div_gen_if #(.WIDTH(8), .PWIDTH(16)) bus ();

    clk_div_gen #(.WIDTH(8), .PWIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: running flag, stop latch, active ratio and position inside the current period.
    logic        m_valid;
    logic        m_run;
    logic        m_stop;
    int          m_n;
    int          m_p;
    logic [15:0] m_pc;

    function automatic int eff(input logic [7:0] d);
        return (d < 8'd2) ? 2 : int'(d);
    endfunction

    initial begin
        m_valid = 1'b0;
        m_run   = 1'b0;
        m_stop  = 1'b0;
        m_n     = 2;
        m_p     = 0;
        m_pc    = '0;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b1;
            m_run   <= 1'b0;
            m_stop  <= 1'b0;
            m_n     <= 2;
            m_p     <= 0;
            m_pc    <= '0;
        end else if (!m_run) begin
            if (bus.en) begin
                m_run  <= 1'b1;
                m_stop <= 1'b0;
                m_n    <= eff(bus.div_val);
                m_p    <= 0;
            end
        end else if (m_p == m_n - 1) begin
            m_pc <= m_pc + 16'd1;
            m_p  <= 0;
            if (!m_stop && bus.en) m_n <= eff(bus.div_val);
            else                   m_run <= 1'b0;
        end else begin
            m_p <= m_p + 1;
            if (!bus.en) m_stop <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic exp_clk;
            logic exp_tick;
            exp_clk  = m_run && (m_p < (m_n - m_n / 2));
            exp_tick = m_run && (m_p == 0);
            vectors++;
            if (bus.clk_out !== exp_clk) begin
                miscompares++;
                $display("FAIL model_clk_out t=%0t actual=%b required=%b", $time, bus.clk_out, exp_clk);
            end
            if (bus.tick !== exp_tick) begin
                miscompares++;
                $display("FAIL model_tick t=%0t actual=%b required=%b", $time, bus.tick, exp_tick);
            end
            if (bus.busy !== m_run) begin
                miscompares++;
                $display("FAIL model_busy t=%0t actual=%b required=%b", $time, bus.busy, m_run);
            end
            if (bus.period_cnt !== m_pc) begin
                miscompares++;
                $display("FAIL model_period_cnt t=%0t actual=%0d required=%0d", $time, bus.period_cnt, m_pc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.en = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Checks clk_out/tick for a steady ratio n starting at the first cycle of a period.
    task automatic chk_pattern(input string name, input int n, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk({name, "_clk"}, int'(bus.clk_out), ((i % n) < (n - n / 2)) ? 1 : 0);
            chk({name, "_tick"}, int'(bus.tick), ((i % n) == 0) ? 1 : 0);
            step();
        end
    endtask

    task automatic start(input logic [7:0] d);
        do_reset();
        bus.div_val = d;
        bus.en = 1'b1;
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.div_val = 8'd4;

        // T1
        do_reset();
        chk("rst_clk_out", int'(bus.clk_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_period_cnt", int'(bus.period_cnt), 0);
        step();
        chk("idle_busy", int'(bus.busy), 0);
        bus.en = 1'b1;
        step();
        chk("t1_start_busy", int'(bus.busy), 1);
        chk_pattern("t1_n4", 4, 12);
        chk("t1_period_cnt", int'(bus.period_cnt), 3);
        chk("t1_tick_13", int'(bus.tick), 1);

        // T2
        start(8'd5);
        chk_pattern("t2_n5", 5, 10);
        start(8'd0);
        chk_pattern("t2_d0", 2, 6);
        start(8'd1);
        chk_pattern("t2_d1", 2, 6);

        // T3
        start(8'd4);
        step();
        bus.div_val = 8'd6;
        step();
        chk("t3_cnt2_clk", int'(bus.clk_out), 0);
        step();
        chk("t3_cnt3_clk", int'(bus.clk_out), 0);
        chk("t3_cnt3_pc", int'(bus.period_cnt), 0);
        step();
        chk("t3_new_pc", int'(bus.period_cnt), 1);
        chk_pattern("t3_n6", 6, 7);

        // T4
        start(8'd8);
        step();
        step();
        bus.en = 1'b0;
        step();
        chk("t4_cnt3_clk", int'(bus.clk_out), 1);
        chk("t4_cnt3_busy", int'(bus.busy), 1);
        step();
        chk("t4_cnt4_clk", int'(bus.clk_out), 0);
        bus.en = 1'b1;
        step();
        bus.en = 1'b0;
        step();
        step();
        chk("t4_cnt7_busy", int'(bus.busy), 1);
        chk("t4_cnt7_clk", int'(bus.clk_out), 0);
        step();
        chk("t4_end_busy", int'(bus.busy), 0);
        chk("t4_end_tick", int'(bus.tick), 0);
        chk("t4_end_pc", int'(bus.period_cnt), 1);
        step();
        chk("t4_idle_clk", int'(bus.clk_out), 0);

        // T5
        start(8'd4);
        step();
        step();
        step();
        chk("t5_cnt3_busy", int'(bus.busy), 1);
        bus.en = 1'b0;
        step();
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_tick", int'(bus.tick), 0);
        chk("t5_clk", int'(bus.clk_out), 0);
        chk("t5_pc", int'(bus.period_cnt), 1);

        // T6
        start(8'd4);
        repeat (4) step();
        chk("t6_pre_pc", int'(bus.period_cnt), 1);
        chk("t6_pre_clk", int'(bus.clk_out), 1);
        rst_n = 1'b0;
        step();
        chk("t6_rst_clk", int'(bus.clk_out), 0);
        chk("t6_rst_tick", int'(bus.tick), 0);
        chk("t6_rst_busy", int'(bus.busy), 0);
        chk("t6_rst_pc", int'(bus.period_cnt), 0);
        rst_n = 1'b1;
        step();
        chk("t6_restart_clk", int'(bus.clk_out), 1);
        chk("t6_restart_tick", int'(bus.tick), 1);
        chk("t6_restart_busy", int'(bus.busy), 1);

        // Odd ratios and the widest ratio, mostly left to the model.
        start(8'd3);
        chk_pattern("n3", 3, 9);
        start(8'd255);
        chk_pattern("n255", 255, 260);
        bus.en = 1'b0;
        repeat (260) step();
        chk("n255_idle_busy", int'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
